multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu_pkg.sv | 26 ++
 rtl/multicycle_alu_carry_adder.sv | 17 +
 rtl/multicycle_alu.sv | 145 ++++++++++++++
 tb/tb_multicycle_alu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multicycle ALU: word width, opcodes, flag bit
// positions and FSM state encoding.
package multicycle_alu_pkg;

  localparam int WORD = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ADC = 2'b11
  } op_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/multicycle_alu_carry_adder.sv
// WIDTH-bit adder with carry in/out, shared by the single-cycle ops and the
// multiply accumulate step.
module carry_adder
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: ADD/SUB/ADC complete in one cycle, MUL is a shift-add
// over WIDTH cycles; results and NZCV flags are registered on entry to DONE.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result_out,
  output logic [3:0]       flags_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e           state_r, state_s;
  op_e              op_s;
  logic [WIDTH-1:0] a_r, b_r, prod_r, result_r;
  logic [3:0]       flags_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] add_x_s, add_y_s, sum_s;
  logic             add_ci_s, add_co_s;
  logic [3:0]       arith_flags_s, mul_flags_s;

  assign op_s = op_e'(op_in);

  // Adder operand select: live inputs while idle, accumulate step in MUL
  always_comb begin
    add_x_s  = a_in;
    add_y_s  = b_in;
    add_ci_s = 1'b0;
    if (state_r == ST_MUL) begin
      add_x_s = prod_r;
      add_y_s = b_r[0] ? a_r : {WIDTH{1'b0}};
    end else begin
      case (op_s)
        OP_SUB:  begin
          add_y_s  = ~b_in;
          add_ci_s = 1'b1;
        end
        OP_ADC:  add_ci_s = flags_r[FLAG_C];
        default: add_ci_s = 1'b0;
      endcase
    end
  end

  carry_adder #(.WIDTH(WIDTH)) u_adder (
    .a         (add_x_s),
    .b         (add_y_s),
    .carry_in  (add_ci_s),
    .sum       (sum_s),
    .carry_out (add_co_s)
  );

  // V uses the possibly-inverted second operand, so SUB overflow falls out too
  assign arith_flags_s = {sum_s[WIDTH-1], (sum_s == {WIDTH{1'b0}}), add_co_s,
                          (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                          (sum_s[WIDTH-1] != add_x_s[WIDTH-1])};
  assign mul_flags_s   = {sum_s[WIDTH-1], (sum_s == {WIDTH{1'b0}}), 1'b0, 1'b0};

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          state_s = (op_s == OP_MUL) ? ST_MUL : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == LAST_ITER) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, multiply iteration and result/flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      prod_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      flags_r  <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            a_r    <= a_in;
            b_r    <= b_in;
            prod_r <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            if (op_s != OP_MUL) begin
              result_r <= sum_s;
              flags_r  <= arith_flags_s;
            end
          end
        end
        ST_MUL: begin
          prod_r <= sum_s;
          a_r    <= a_r << 1;
          b_r    <= b_r >> 1;
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            result_r <= sum_s;
            flags_r  <= mul_flags_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign result_out = result_r;
  assign flags_out  = flags_r;
  assign busy_out   = (state_r != ST_IDLE);
  assign done_out   = (state_r == ST_DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_in;
  logic [1:0]   op_in;
  logic [W-1:0] a_in, b_in;
  logic [W-1:0] result_out;
  logic [3:0]   flags_out;
  logic         busy_out, done_out;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] model_result;
  logic [3:0]   model_flags;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
    .op_in      (op_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .result_out (result_out),
    .flags_out  (flags_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: plain arithmetic on the operand values
  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, b,
                                    input logic cin, output logic [W-1:0] res,
                                    output logic [3:0] fl);
    logic [W:0] wide;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[W-1:0];
        c    = wide[W];
        v    = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      2'b01: begin
        res = a - b;
        c   = (a >= b);
        v   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      2'b10: res = a * b;
      default: begin
        wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        res  = wide[W-1:0];
        c    = wide[W];
        v    = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
    endcase
    fl = {res[W-1], (res == {W{1'b0}}), c, v};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, watch latency/busy/hold, then check the result
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, input int stray_at);
    logic [W-1:0] exp_res;
    logic [3:0]   exp_fl;
    int           cycles, exp_lat;
    logic         busy_bad, hold_bad;
    ref_model(op, a, b, model_flags[FLAG_C], exp_res, exp_fl);
    exp_lat = (op == 2'b10) ? W + 1 : 1;
    @(negedge clk);
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    @(negedge clk);
    start_in = 1'b0;
    a_in     = rnd64();
    b_in     = rnd64();
    op_in    = 2'($urandom_range(0, 3));
    cycles   = 1;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    while (done_out !== 1'b1 && cycles < 200) begin
      if (busy_out !== 1'b1) busy_bad = 1'b1;
      if (result_out !== model_result || flags_out !== model_flags) hold_bad = 1'b1;
      start_in = (cycles == stray_at);
      if (start_in) op_in = 2'b00;
      @(negedge clk);
      cycles++;
    end
    start_in = 1'b0;
    chk("latency", W'(cycles), W'(exp_lat));
    chk("busy_during_op", W'(busy_bad), W'(0));
    chk("hold_before_done", W'(hold_bad), W'(0));
    chk("result", result_out, exp_res);
    chk("flags", W'(flags_out), W'(exp_fl));
    chk("busy_at_done", W'(busy_out), W'(1));
    model_result = exp_res;
    model_flags  = exp_fl;
    @(negedge clk);
    chk("done_one_cycle", W'(done_out), W'(0));
    chk("idle_after_done", W'(busy_out), W'(0));
  endtask

  initial begin
    int no_done;
    reset        = 1'b1;
    start_in     = 1'b0;
    op_in        = 2'b00;
    a_in         = '0;
    b_in         = '0;
    model_result = '0;
    model_flags  = 4'b0000;

    repeat (2) @(negedge clk);
    chk("reset_result", result_out, W'(0));
    chk("reset_flags", W'(flags_out), W'(0));
    chk("reset_busy", W'(busy_out), W'(0));
    chk("reset_done", W'(done_out), W'(0));
    reset = 1'b0;

    // Directed corner cases
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("add_wrap_nzcv", W'(flags_out), W'(4'b0110));
    run_op(2'b11, 64'd2, 64'd3, 0);
    chk("adc_carry_result", result_out, W'(6));
    run_op(2'b01, 64'd5, 64'd7, 0);
    chk("sub_neg_nzcv", W'(flags_out), W'(4'b1000));
    run_op(2'b01, 64'd7, 64'd5, 0);
    chk("sub_pos_nzcv", W'(flags_out), W'(4'b0010));
    run_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    chk("add_ovf_nzcv", W'(flags_out), W'(4'b1001));
    run_op(2'b10, 64'd3, 64'd5, 10);
    chk("mul_3x5", result_out, W'(15));

    // Reset in the middle of a multiply
    @(negedge clk);
    start_in = 1'b1;
    op_in    = 2'b10;
    a_in     = rnd64();
    b_in     = rnd64();
    @(negedge clk);
    start_in = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midmul_reset_result", result_out, W'(0));
    chk("midmul_reset_flags", W'(flags_out), W'(0));
    chk("midmul_reset_busy", W'(busy_out), W'(0));
    chk("midmul_reset_done", W'(done_out), W'(0));
    repeat (2) @(negedge clk);
    reset        = 1'b0;
    model_result = '0;
    model_flags  = 4'b0000;
    no_done      = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_out !== 1'b0) no_done++;
    end
    chk("no_done_after_reset", W'(no_done), W'(0));
    run_op(2'b00, 64'd1, 64'd1, 0);
    chk("add_after_reset", result_out, W'(2));

    // Random operations, with an occasional stray start while busy
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (i % 5 == 0) begin
        run_op(op, W'($urandom_range(0, 15)), rnd64(), 0);
      end else begin
        run_op(op, rnd64(), rnd64(), (op == 2'b10) ? int'($urandom_range(1, 60)) : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
